// File: rtl/bcd_countdown_timer_if.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer_if
//   Control and status bundle for bcd_countdown_timer.
//   master : drives tick/count_up/load/load_value/start/stop/clear and
//            observes digits/running/paused/alarm/done_pulse/flash.
//   slave  : the timer core side (opposite directions).
// ---------------------------------------------------------------------------
interface bcd_countdown_timer_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                    tick;
  logic                    count_up;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_value;
  logic                    start;
  logic                    stop;
  logic                    clear;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    running;
  logic                    paused;
  logic                    alarm;
  logic                    done_pulse;
  logic                    flash;

  modport master (
    output tick, count_up, load, load_value, start, stop, clear,
    input  digits, running, paused, alarm, done_pulse, flash
  );

  modport slave (
    input  tick, count_up, load, load_value, start, stop, clear,
    output digits, running, paused, alarm, done_pulse, flash
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer
//   Parametrised BCD countdown / stopwatch core with start/stop/clear
//   control, sticky alarm, one-cycle done pulse and a status-LED flash.
//
//   Ports:
//     clk   - system clock
//     reset - asynchronous, active-high reset
//     tmr   - bcd_countdown_timer_if.slave
//             inputs : tick, count_up, load, load_value, start, stop, clear
//             outputs: digits (BCD, digit 0 least significant), running,
//                      paused, alarm, done_pulse, flash (all registered)
//
//   Parameters:
//     NUM_DIGITS - number of BCD digits
//     DIGIT_MAX  - packed per-digit maximum, digit i at [4i+3:4i], 1..9
//
//   Per-cycle input priority: clear > load > stop > start > tick. The
//   winning input consumes the cycle even when it has no effect in the
//   current state (load in RUN is treated as absent).
// ---------------------------------------------------------------------------
module bcd_countdown_timer #(
  parameter int unsigned             NUM_DIGITS = 4,
  parameter logic [4*NUM_DIGITS-1:0] DIGIT_MAX  = 16'h5959
) (
  input  logic                 clk,
  input  logic                 reset,
  bcd_countdown_timer_if.slave tmr
);

  localparam int unsigned W = 4 * NUM_DIGITS;

  // Encoding chosen so running/paused/alarm are plain state register bits.
  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_RUN   = 3'b001,
    S_PAUSE = 3'b010,
    S_DONE  = 3'b100
  } state_t;

  state_t         state_q;
  logic [W-1:0]   digits_q;
  logic           up_q;
  logic           flash_q;
  logic           done_pulse_q;

  logic [W-1:0]   dec_val;
  logic [W-1:0]   inc_val;
  logic [W-1:0]   clamp_val;
  logic           borrow;
  logic           carry;
  logic           dec_zero;
  logic           inc_full;

  // Ripple-borrow decrement, ripple-carry increment and per-nibble load
  // clamp, all evaluated against the current count.
  always_comb begin
    dec_val   = digits_q;
    inc_val   = digits_q;
    clamp_val = '0;
    borrow    = 1'b1;
    carry     = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (borrow) begin
        if (digits_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = DIGIT_MAX[4*i +: 4];
        end else begin
          dec_val[4*i +: 4] = digits_q[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
      if (carry) begin
        if (digits_q[4*i +: 4] == DIGIT_MAX[4*i +: 4]) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
      if (tmr.load_value[4*i +: 4] > DIGIT_MAX[4*i +: 4]) begin
        clamp_val[4*i +: 4] = DIGIT_MAX[4*i +: 4];
      end else begin
        clamp_val[4*i +: 4] = tmr.load_value[4*i +: 4];
      end
    end
    dec_zero = (dec_val == '0);
    inc_full = (inc_val == DIGIT_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      digits_q     <= '0;
      up_q         <= 1'b0;
      flash_q      <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      done_pulse_q <= 1'b0;
      if (tmr.clear) begin
        digits_q <= '0;
        state_q  <= S_IDLE;
        flash_q  <= 1'b0;
      end else if (tmr.load && (state_q != S_RUN)) begin
        digits_q <= clamp_val;
        state_q  <= S_IDLE;
        flash_q  <= 1'b0;
      end else if (tmr.stop) begin
        if (state_q == S_RUN) begin
          state_q <= S_PAUSE;
          flash_q <= 1'b0;
        end
      end else if (tmr.start) begin
        case (state_q)
          S_IDLE: begin
            // A countdown from zero would finish immediately; refuse it.
            if (tmr.count_up || (digits_q != '0)) begin
              state_q <= S_RUN;
              up_q    <= tmr.count_up;
            end
          end
          S_PAUSE: state_q <= S_RUN;
          S_DONE: begin
            state_q <= S_IDLE;
            flash_q <= 1'b0;
          end
          default: ;
        endcase
      end else if (tmr.tick) begin
        case (state_q)
          S_RUN: begin
            flash_q <= ~flash_q;
            if (up_q) begin
              digits_q <= inc_val;
              if (inc_full) begin
                state_q      <= S_DONE;
                done_pulse_q <= 1'b1;
              end
            end else begin
              digits_q <= dec_val;
              if (dec_zero) begin
                state_q      <= S_DONE;
                done_pulse_q <= 1'b1;
              end
            end
          end
          S_DONE:  flash_q <= ~flash_q;
          default: ;
        endcase
      end
    end
  end

  assign tmr.digits     = digits_q;
  assign tmr.running    = state_q[0];
  assign tmr.paused     = state_q[1];
  assign tmr.alarm      = state_q[2];
  assign tmr.done_pulse = done_pulse_q;
  assign tmr.flash      = flash_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_bcd_countdown_timer
//   Drives a 4-digit MM:SS instance and a 6-digit HH:MM:SS instance with the
//   same control stream and checks both against a mixed-radix integer model.
// ---------------------------------------------------------------------------
module tb_bcd_countdown_timer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bcd_countdown_timer_if #(.NUM_DIGITS(4)) ia ();
  bcd_countdown_timer_if #(.NUM_DIGITS(6)) ib ();

  bcd_countdown_timer #(.NUM_DIGITS(4), .DIGIT_MAX(16'h5959)) dut_a (
    .clk(clk), .reset(reset), .tmr(ia)
  );
  bcd_countdown_timer #(.NUM_DIGITS(6), .DIGIT_MAX(24'h995959)) dut_b (
    .clk(clk), .reset(reset), .tmr(ib)
  );

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;

  int          nd [2] = '{4, 6};
  logic [23:0] mx [2] = '{24'h005959, 24'h995959};

  logic [23:0] m_dig [2];
  mstate_t     m_st  [2];
  logic        m_up  [2];
  logic        m_fl  [2];
  logic        m_dp  [2];

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Number of distinct counts the digit chain can hold.
  function automatic int span(int k);
    int n;
    n = 1;
    for (int i = 0; i < nd[k]; i++) n = n * (int'(mx[k][4*i +: 4]) + 1);
    return n;
  endfunction

  function automatic int to_val(int k, logic [23:0] d);
    int v, w;
    v = 0;
    w = 1;
    for (int i = 0; i < nd[k]; i++) begin
      v = v + int'(d[4*i +: 4]) * w;
      w = w * (int'(mx[k][4*i +: 4]) + 1);
    end
    return v;
  endfunction

  function automatic logic [23:0] from_val(int k, int val);
    logic [23:0] d;
    int v, r;
    d = '0;
    v = val;
    for (int i = 0; i < nd[k]; i++) begin
      r = int'(mx[k][4*i +: 4]) + 1;
      d[4*i +: 4] = 4'(v % r);
      v = v / r;
    end
    return d;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_dig[k] = '0;
      m_st[k]  = M_IDLE;
      m_up[k]  = 1'b0;
      m_fl[k]  = 1'b0;
      m_dp[k]  = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input bit tk, input bit sa, input bit sp,
                            input bit ld, input bit cl, input bit cu,
                            input logic [23:0] lv);
    int v, n;
    logic [23:0] c;
    m_dp[k] = 1'b0;
    if (cl) begin
      m_dig[k] = '0;
      m_st[k]  = M_IDLE;
      m_fl[k]  = 1'b0;
    end else if (ld && m_st[k] != M_RUN) begin
      c = '0;
      for (int i = 0; i < nd[k]; i++)
        c[4*i +: 4] = (lv[4*i +: 4] > mx[k][4*i +: 4]) ? mx[k][4*i +: 4] : lv[4*i +: 4];
      m_dig[k] = c;
      m_st[k]  = M_IDLE;
      m_fl[k]  = 1'b0;
    end else if (sp) begin
      if (m_st[k] == M_RUN) begin
        m_st[k] = M_PAUSE;
        m_fl[k] = 1'b0;
      end
    end else if (sa) begin
      if (m_st[k] == M_IDLE) begin
        if (cu || m_dig[k] != 24'h0) begin
          m_st[k] = M_RUN;
          m_up[k] = cu;
        end
      end else if (m_st[k] == M_PAUSE) begin
        m_st[k] = M_RUN;
      end else if (m_st[k] == M_DONE) begin
        m_st[k] = M_IDLE;
        m_fl[k] = 1'b0;
      end
    end else if (tk) begin
      if (m_st[k] == M_RUN) begin
        n = span(k);
        v = to_val(k, m_dig[k]);
        v = m_up[k] ? (v + 1) % n : ((v == 0) ? n - 1 : v - 1);
        m_dig[k] = from_val(k, v);
        m_fl[k]  = ~m_fl[k];
        if (m_up[k] ? (v == n - 1) : (v == 0)) begin
          m_st[k] = M_DONE;
          m_dp[k] = 1'b1;
        end
      end else if (m_st[k] == M_DONE) begin
        m_fl[k] = ~m_fl[k];
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic cmp_inst(input int k, input logic [23:0] ad, input logic [4:0] af);
    logic [4:0] ef;
    ef = {m_st[k] == M_RUN, m_st[k] == M_PAUSE, m_st[k] == M_DONE, m_dp[k], m_fl[k]};
    checks++;
    if (ad !== m_dig[k]) begin
      errors++;
      $display("FAIL model_digits[%0d] t=%0t: got %h, expected %h", k, $time, ad, m_dig[k]);
    end
    checks++;
    if (af !== ef) begin
      errors++;
      $display("FAIL model_flags[%0d] (run,pause,alarm,done,flash) t=%0t: got %b, expected %b",
               k, $time, af, ef);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      cmp_inst(0, {8'h00, ia.digits}, {ia.running, ia.paused, ia.alarm, ia.done_pulse, ia.flash});
      cmp_inst(1, ib.digits, {ib.running, ib.paused, ib.alarm, ib.done_pulse, ib.flash});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit tk, input bit sa, input bit sp, input bit ld,
                     input bit cl, input bit cu, input logic [23:0] lv);
    @(negedge clk);
    ia.tick = tk; ia.start = sa; ia.stop = sp; ia.load = ld; ia.clear = cl;
    ia.count_up = cu; ia.load_value = lv[15:0];
    ib.tick = tk; ib.start = sa; ib.stop = sp; ib.load = ld; ib.clear = cl;
    ib.count_up = cu; ib.load_value = lv;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, tk, sa, sp, ld, cl, cu, lv);
    #1;
  endtask

  task automatic idle();   cyc(0, 0, 0, 0, 0, 0, 24'h0); endtask
  task automatic tick1();  cyc(1, 0, 0, 0, 0, 0, 24'h0); endtask
  task automatic clr();    cyc(0, 0, 0, 0, 1, 0, 24'h0); endtask
  task automatic ldv(input logic [23:0] v); cyc(0, 0, 0, 1, 0, 0, v); endtask

  initial begin
    reset = 1'b1;
    ia.tick = 0; ia.start = 0; ia.stop = 0; ia.load = 0; ia.clear = 0;
    ia.count_up = 0; ia.load_value = '0;
    ib.tick = 0; ib.start = 0; ib.stop = 0; ib.load = 0; ib.clear = 0;
    ib.count_up = 0; ib.load_value = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_digits_a", {8'h0, ia.digits}, 24'h0);
    chk("reset_flags_a", {19'h0, ia.running, ia.paused, ia.alarm, ia.done_pulse, ia.flash}, 24'h0);
    chk("reset_digits_b", ib.digits, 24'h0);
    #1;
    reset = 1'b0;
    model_reset();
    check_en = 1'b1;

    // 01:30 countdown, 90 ticks to zero
    ldv(24'h000130);
    cyc(0, 1, 0, 0, 0, 0, 24'h0);
    for (int t = 1; t <= 90; t++) begin
      tick1();
      if (t == 1)  chk("cd_first_tick", {8'h0, ia.digits}, 24'h0129);
      if (t == 30) chk("cd_to_0100", {8'h0, ia.digits}, 24'h0100);
      if (t == 31) chk("cd_borrow_0059", {8'h0, ia.digits}, 24'h0059);
      if (t == 90) begin
        chk("cd_zero", {8'h0, ia.digits}, 24'h0000);
        chk("cd_alarm_pulse", {22'h0, ia.alarm, ia.done_pulse}, 24'h3);
      end
    end
    repeat (3) tick1();
    chk("cd_after_done", {8'h0, ia.digits, 7'h0, ia.alarm}, {8'h0, 16'h0000, 8'h01} >> 0);

    // pause / resume
    ldv(24'h000005);
    cyc(0, 1, 0, 0, 0, 0, 24'h0);
    tick1(); tick1();
    cyc(0, 0, 1, 0, 0, 0, 24'h0);
    chk("pause_digits", {8'h0, ia.digits}, 24'h0003);
    repeat (3) tick1();
    chk("pause_hold", {8'h0, ia.digits}, 24'h0003);
    chk("pause_flags", {22'h0, ia.paused, ia.flash}, 24'h2);
    cyc(0, 1, 0, 0, 0, 0, 24'h0);
    repeat (3) tick1();
    chk("resume_end", {8'h0, ia.digits}, 24'h0000);
    chk("resume_alarm", {23'h0, ia.alarm}, 24'h1);

    // simultaneous events
    ldv(24'h000010);
    cyc(1, 1, 0, 0, 0, 0, 24'h0);
    chk("start_tick", {8'h0, ia.digits}, 24'h0010);
    chk("start_tick_run", {23'h0, ia.running}, 24'h1);
    cyc(1, 0, 1, 0, 0, 0, 24'h0);
    chk("stop_tick", {8'h0, ia.digits}, 24'h0010);
    chk("stop_tick_pause", {23'h0, ia.paused}, 24'h1);
    cyc(0, 1, 1, 0, 0, 0, 24'h0);
    chk("start_stop_pause", {22'h0, ia.running, ia.paused}, 24'h1);

    // clamp and zero-start guard
    clr();
    ldv(24'h00F9C9);
    chk("clamp_a", {8'h0, ia.digits}, 24'h5959);
    chk("clamp_b", ib.digits, 24'h005959);
    clr();
    cyc(0, 1, 0, 0, 0, 0, 24'h0);
    chk("zero_start_guard", {7'h0, ia.digits, ia.running}, 24'h0);

    // stopwatch saturates at 59:59
    ldv(24'h005957);
    cyc(0, 1, 0, 0, 0, 1, 24'h0);
    tick1();
    chk("up_5958", {8'h0, ia.digits}, 24'h5958);
    tick1();
    chk("up_5959", {8'h0, ia.digits}, 24'h5959);
    chk("up_done", {22'h0, ia.alarm, ia.done_pulse}, 24'h3);
    idle();
    chk("up_pulse_once", {22'h0, ia.alarm, ia.done_pulse}, 24'h2);
    cyc(0, 1, 0, 0, 0, 0, 24'h0);
    chk("ack_idle", {8'h0, ia.digits}, 24'h5959);
    chk("ack_flags", {21'h0, ia.running, ia.paused, ia.alarm}, 24'h0);

    // six-digit variant and async reset mid-run
    clr();
    ldv(24'h010000);
    cyc(0, 1, 0, 0, 0, 0, 24'h0);
    tick1();
    chk("hms_borrow", ib.digits, 24'h005959);
    tick1();
    chk("hms_running", {23'h0, ib.running}, 24'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_digits_b", ib.digits, 24'h0);
    chk("async_rst_flags_b", {19'h0, ib.running, ib.paused, ib.alarm, ib.done_pulse, ib.flash}, 24'h0);
    model_reset();
    #1;
    reset = 1'b0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit tk, sa, sp, ld, cl, cu;
      logic [23:0] lv;
      tk = ($urandom_range(0, 1) == 1);
      sa = ($urandom_range(0, 11) == 0);
      sp = ($urandom_range(0, 31) == 0);
      ld = ($urandom_range(0, 19) == 0);
      cl = ($urandom_range(0, 79) == 0);
      cu = ($urandom_range(0, 1) == 1);
      lv = 24'($urandom);
      if ($urandom_range(0, 1) == 1) lv = lv & 24'h000031;
      cyc(tk, sa, sp, ld, cl, cu, lv);
    end

    idle();
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Parametrised BCD timer core that replaces the fixed four-digit MM:SS counter.
- Configurable digit count and per-digit modulus, so the same block covers MM:SS and HH:MM:SS.
- Counts down, or up as a stopwatch, with a start/stop/clear control state machine, a sticky alarm and a flash output for the status LED.
- Sits between the 1 s pulse divider (tick) and the seven-segment display mux.

Parameters:
- NUM_DIGITS, 4: number of BCD digits; digit 0 is least significant.
- DIGIT_MAX, 16'h5959: packed 4-bit maximum value per digit, digit i at [4i+3:4i]. Width is 4*NUM_DIGITS; each nibble is in the range 1..9.

Ports:
- clk  input  1  system clock (5 MHz domain)
- reset  input  1  asynchronous, active-high reset
- tick  input  1  one-cycle count-enable pulse (1 s)
- count_up  input  1  0 = count down, 1 = count up (stopwatch); sampled only in IDLE
- load  input  1  load load_value into the digits
- load_value  input  4*NUM_DIGITS  programmed time, BCD
- start  input  1  start or resume counting
- stop  input  1  pause counting
- clear  input  1  zero the digits, go to IDLE
- digits  output  4*NUM_DIGITS  current count, BCD, registered
- running  output  1  high in RUN
- paused  output  1  high in PAUSE
- alarm  output  1  high in DONE (sticky)
- done_pulse  output  1  one-cycle pulse on entry to DONE
- flash  output  1  status-LED blink

Behaviour:
- Reset (asynchronous) sets: state IDLE, digits 0, running/paused/alarm/done_pulse/flash 0, latched direction = down.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered and update on the clk edge that samples the inputs.
- Input priority per cycle: clear > load > stop > start > tick.
- clear, any state: digits <= 0; state <= IDLE; flash <= 0; alarm drops the next cycle.
- load, ignored in RUN. In IDLE, PAUSE and DONE:
  - digits <= load_value, with each nibble clamped to its DIGIT_MAX nibble (e.g. 4'hC in a max-5 digit loads 5).
  - state <= IDLE.
- start:
  - IDLE -> RUN, latching count_up. Ignored if counting down and digits == 0.
  - PAUSE -> RUN, keeping the latched direction.
  - DONE -> IDLE (alarm acknowledge); digits unchanged.
  - A tick in the same cycle as a start is not counted; the first count happens on the next tick.
- stop:
  - RUN -> PAUSE; a tick in the same cycle is not counted.
  - Ignored in other states.
  - start and stop together: stop wins. RUN goes to PAUSE; IDLE, PAUSE and DONE are unchanged.
- tick in RUN, count down:
  - Ripple-borrow decrement. A digit at 0 becomes its DIGIT_MAX and borrows from the next digit; the top digit never borrows.
  - If the result is all zeros: state -> DONE, done_pulse = 1 for exactly one cycle.
- tick in RUN, count up:
  - Ripple-carry increment. A digit at DIGIT_MAX becomes 0 and carries into the next digit.
  - If the result equals all digits at DIGIT_MAX: state -> DONE (saturate, no wrap), done_pulse pulses.
- tick in IDLE, PAUSE or DONE: digits unchanged.
- Out-of-range BCD cannot occur after load because values are clamped.
- flash:
  - Toggles on every tick in RUN or DONE.
  - Held 0 in IDLE and PAUSE.
  - Forced 0 on entry to PAUSE/IDLE.
- Status outputs:
  - running = (state == RUN).
  - paused = (state == PAUSE).
  - alarm = (state == DONE).
- Latency: digits reflect a tick one clock after the tick cycle. There is no combinational path from inputs to outputs.
- Reset mid-count: immediate asynchronous return to the reset values; the programmed value is lost.

Test Plan:
- Reset, then load 16'h0130 and start, then 90 ticks: digits steps 0130 -> 0129 -> ... -> 0100 -> 0059 -> ... -> 0000. done_pulse high for 1 cycle and alarm = 1 on the 90th tick; further ticks change nothing.
- Load 16'h0005, start, 2 ticks, stop, 3 ticks, start, 3 ticks: digits = 0003 after the stop and during the pause. paused = 1 and flash = 0 while paused. digits = 0000 and alarm = 1 at the end.
- Simultaneous events, with digits 0010:
  - start+tick in IDLE: next digits 0010, running = 1.
  - stop+tick in RUN: digits unchanged, paused = 1.
  - start+stop in PAUSE: remains in PAUSE.
- Clamp and guard: load 16'hF9C9 -> digits 5959. Then clear, then start with digits 0000 and count_up = 0: stays IDLE, running = 0.
- Stopwatch: count_up = 1, load 16'h5957, start, 2 ticks -> 5959, alarm = 1, done_pulse pulses once. Then start -> IDLE with digits still 5959.
- Parameter variant NUM_DIGITS = 6, DIGIT_MAX = 24'h995959 (hours digit pair 0..99):
  - Load 24'h010000, start, 1 tick -> 005959.
  - Assert reset mid-run -> all outputs 0 asynchronously, before the next clk edge.
